// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scanner for DIGITS common-anode 7-segment digits.
//
// The packed hex word is captured once per frame into shadow registers, so the
// displayed frame is tear-free. The block also handles per-digit enables, decimal
// points, leading-zero blanking, an anti-ghost blank at the start of each digit
// slot, and 16-level PWM brightness.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   data         hex nibbles, digit i = data[4i+3:4i]
//   dp_in        decimal point request per digit
//   digit_en     1 = digit may light, 0 = anode held off
//   lz_suppress  1 = blank leading zero digits
//   bright       brightness 0 (dark) .. 15 (full), applied live
//   an           anode enables, at most one active
//   seg          segments {g,f,e,d,c,b,a}
//   dp           decimal point
//   frame_done   1-cycle pulse on the last cycle of slot DIGITS-1 (as seen at the pins)
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned TICK_DIV     = 12500,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lz_suppress,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int unsigned SW = $clog2(TICK_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SW-1:0]     LAST_SLOT = SW'(TICK_DIV - 1);
    localparam logic [SW-1:0]     BLANK_END = SW'(BLANK_CYCLES);
    localparam logic [IW-1:0]     LAST_IDX  = IW'(DIGITS - 1);

    // Inactive pin levels; XOR-ing an active-high value with these gives the pin value.
    localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]        SEG_OFF   = {7{ACTIVE_LOW}};
    localparam logic              DP_OFF    = ACTIVE_LOW;

    logic [SW-1:0]         slot_cnt_q;
    logic [IW-1:0]         idx_q;
    logic                  load_pending_q;
    logic [4*DIGITS-1:0]   shadow_data_q;
    logic [DIGITS-1:0]     shadow_dp_q;
    logic [DIGITS-1:0]     shadow_en_q;
    logic                  shadow_lz_q;

    logic                  slot_last;
    logic                  idx_last;
    logic                  capture;
    logic [3:0]            nib [DIGITS];
    logic [DIGITS-1:0]     lz_blank;
    logic                  higher_zero;
    logic [SW-1:0]         slot_off;
    logic [3:0]            pwm;
    logic                  in_blank;
    logic                  lit;
    logic [DIGITS-1:0]     an_act;
    logic [6:0]            seg_act;
    logic                  dp_act;

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        case (h)
            4'h0:    hex_decode = 7'h3F;
            4'h1:    hex_decode = 7'h06;
            4'h2:    hex_decode = 7'h5B;
            4'h3:    hex_decode = 7'h4F;
            4'h4:    hex_decode = 7'h66;
            4'h5:    hex_decode = 7'h6D;
            4'h6:    hex_decode = 7'h7D;
            4'h7:    hex_decode = 7'h07;
            4'h8:    hex_decode = 7'h7F;
            4'h9:    hex_decode = 7'h6F;
            4'hA:    hex_decode = 7'h77;
            4'hB:    hex_decode = 7'h7C;
            4'hC:    hex_decode = 7'h39;
            4'hD:    hex_decode = 7'h5E;
            4'hE:    hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        assign nib[g] = shadow_data_q[4*g +: 4];
    end

    assign slot_last = (slot_cnt_q == LAST_SLOT);
    assign idx_last  = (idx_q == LAST_IDX);
    // Shadow registers load on the edge that starts slot 0 of a new frame.
    assign capture   = load_pending_q | (slot_last & idx_last);

    // Digit i>0 is blanked when it and every higher digit are zero.
    always_comb begin
        higher_zero = 1'b1;
        lz_blank    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero & (nib[i] == 4'h0);
            lz_blank[i] = shadow_lz_q & higher_zero & (i != 0);
        end
    end

    always_comb begin
        slot_off = slot_cnt_q - BLANK_END;
        pwm      = slot_off[3:0];
        in_blank = (slot_cnt_q < BLANK_END);
        lit      = !in_blank && shadow_en_q[idx_q] && !lz_blank[idx_q] &&
                   ((bright == 4'hF) || (pwm < bright));
        an_act        = '0;
        an_act[idx_q] = lit;
        seg_act  = lit ? hex_decode(nib[idx_q]) : 7'h00;
        dp_act   = lit & shadow_dp_q[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q     <= '0;
            idx_q          <= '0;
            load_pending_q <= 1'b1;
            shadow_data_q  <= '0;
            shadow_dp_q    <= '0;
            shadow_en_q    <= '0;
            shadow_lz_q    <= 1'b0;
            an             <= AN_OFF;
            seg            <= SEG_OFF;
            dp             <= DP_OFF;
            frame_done     <= 1'b0;
        end else begin
            slot_cnt_q <= slot_last ? '0 : slot_cnt_q + SW'(1);
            if (slot_last) begin
                idx_q <= idx_last ? '0 : idx_q + IW'(1);
            end
            load_pending_q <= 1'b0;
            if (capture) begin
                shadow_data_q <= data;
                shadow_dp_q   <= dp_in;
                shadow_en_q   <= digit_en;
                shadow_lz_q   <= lz_suppress;
            end
            an         <= an_act ^ AN_OFF;
            seg        <= seg_act ^ SEG_OFF;
            dp         <= dp_act ^ DP_OFF;
            frame_done <= slot_last & idx_last;
        end
    end

endmodule
